// File: rtl/stepgen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stepgen_pkg
// Description : Shared state encodings, default drain length and bus-slice
//               helper for the stepgen multi-axis scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package stepgen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    // One steptime plus one dirtime at T=5: 2*2^5+2
    localparam int c_drain_cyc = 66;

    // LSB offset of axis idx in a flattened bus of width-bit slices
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stepgen_wdog.sv
`default_nettype none
// ============================================================================
// Module      : stepgen_wdog
// Description : Loadable down-counter with a zero-disable input and an
//               expire pulse when an enabled cycle sits at EXPIRE_AT.
// Revision    : 1.0 - initial release
// ============================================================================
module stepgen_wdog #(
    parameter int WIDTH     = 24,
    parameter int EXPIRE_AT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             count_en,
    input  logic             zero_dis,
    output logic             expire
);

    logic [WIDTH-1:0] r_count;
    logic             w_run;

    // A load in the same cycle always wins over counting and expiry
    assign w_run  = count_en && !zero_dis && !load;
    assign expire = w_run && (r_count == WIDTH'(EXPIRE_AT));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (w_run && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/stepgen_sched.sv
`default_nettype none
// ============================================================================
// Module      : stepgen_sched
// Description : Multi-axis commit sequencer with watchdog-driven safe stop
//               and shared stepgen enable sequencing.
// Revision    : 1.0 - initial release
// ============================================================================
module stepgen_sched
    import stepgen_pkg::*;
#(
    parameter int N         = 4,
    parameter int W         = 12,
    parameter int F         = 10,
    parameter int WD_W      = 24,
    parameter int DRAIN_CYC = c_drain_cyc
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [$clog2(N)-1:0]   wr_sel,
    input  logic [F:0]             wr_data,
    input  logic                   commit,
    input  logic                   enable_req,
    input  logic [WD_W-1:0]        wd_timeout,
    input  logic [N*(W+F)-1:0]     pos_in,
    output logic [N*(F+1)-1:0]     vel_out,
    output logic                   sg_enable,
    output logic [N*(W+F)-1:0]     snap_pos,
    output logic                   snap_valid,
    output logic                   wd_tripped,
    output logic [1:0]             state_o
);

    localparam int c_sel_w   = $clog2(N);
    localparam int c_drain_w = $clog2(DRAIN_CYC + 1);

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   r_fault_pend;
    logic                   w_fault_next;
    logic [N*(F+1)-1:0]     w_eff;
    logic [N*(F+1)-1:0]     r_vel;
    logic [N*(W+F)-1:0]     r_snap;
    logic                   r_snap_valid;
    logic                   r_sg_enable;
    logic                   r_wd_tripped;
    logic                   w_commit_ok;
    logic                   w_wd_expire;
    logic                   w_drain_load;
    logic                   w_drain_expire;

    // Shadow registers; the effective value writes through on a same-cycle write
    for (genvar gi = 0; gi < N; gi++) begin : g_axis
        logic [F:0] r_shadow;
        logic       w_hit;

        assign w_hit = wr_en && (wr_sel == c_sel_w'(gi));
        assign w_eff[slice_lo(gi, F + 1) +: F + 1] = w_hit ? wr_data : r_shadow;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_shadow <= '0;
            end else if (w_hit) begin
                r_shadow <= wr_data;
            end
        end
    end

    assign w_commit_ok = commit && enable_req &&
                         ((r_state == ST_IDLE) || (r_state == ST_RUN));

    stepgen_wdog #(
        .WIDTH     (WD_W),
        .EXPIRE_AT (1)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .load     (w_commit_ok),
        .load_val (wd_timeout),
        .count_en (r_state == ST_RUN),
        .zero_dis (wd_timeout == '0),
        .expire   (w_wd_expire)
    );

    // Drain leaves at count zero, so it runs for DRAIN_CYC cycles after loading DRAIN_CYC-1
    assign w_drain_load = (r_state == ST_RUN) && (w_state_next == ST_DRAIN);

    stepgen_wdog #(
        .WIDTH     (c_drain_w),
        .EXPIRE_AT (0)
    ) u_drain (
        .clk      (clk),
        .reset    (reset),
        .load     (w_drain_load),
        .load_val (c_drain_w'(DRAIN_CYC - 1)),
        .count_en (r_state == ST_DRAIN),
        .zero_dis (1'b0),
        .expire   (w_drain_expire)
    );

    always_comb begin
        w_state_next = r_state;
        w_fault_next = r_fault_pend;
        case (r_state)
            ST_IDLE: begin
                w_fault_next = 1'b0;
                if (commit && enable_req) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!enable_req) begin
                    w_state_next = ST_DRAIN;
                    w_fault_next = 1'b0;
                end else if (w_wd_expire) begin
                    w_state_next = ST_DRAIN;
                    w_fault_next = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (w_drain_expire) begin
                    w_state_next = r_fault_pend ? ST_FAULT : ST_IDLE;
                end
            end
            ST_FAULT: begin
                w_fault_next = 1'b0;
                if (!enable_req) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_fault_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_fault_pend <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_fault_pend <= w_fault_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vel        <= '0;
            r_snap       <= '0;
            r_snap_valid <= 1'b0;
            r_sg_enable  <= 1'b0;
            r_wd_tripped <= 1'b0;
        end else begin
            // Velocity is only ever non-zero while the next state is RUN
            if (w_commit_ok) begin
                r_vel <= w_eff;
            end else if (w_state_next != ST_RUN) begin
                r_vel <= '0;
            end
            if (w_commit_ok) begin
                r_snap <= pos_in;
            end
            r_snap_valid <= w_commit_ok;
            r_sg_enable  <= (w_state_next == ST_RUN) || (w_state_next == ST_DRAIN);
            r_wd_tripped <= (w_state_next == ST_FAULT);
        end
    end

    assign vel_out    = r_vel;
    assign snap_pos   = r_snap;
    assign snap_valid = r_snap_valid;
    assign sg_enable  = r_sg_enable;
    assign wd_tripped = r_wd_tripped;
    assign state_o    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_stepgen_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_stepgen_sched
// Description : Directed table-driven bench for stepgen_sched (3 axes, 8-bit
//               watchdog so wr_sel = N and counter wrap are reachable).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stepgen_sched;

    localparam int c_n    = 3;
    localparam int c_w    = 12;
    localparam int c_f    = 10;
    localparam int c_wd_w = 8;
    localparam int c_vw   = c_n * (c_f + 1);
    localparam int c_pw   = c_n * (c_w + c_f);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_run   = 2'd1;
    localparam logic [1:0] c_drain = 2'd2;
    localparam logic [1:0] c_fault = 2'd3;

    logic              clk;
    logic              reset;
    logic              wr_en;
    logic [1:0]        wr_sel;
    logic [c_f:0]      wr_data;
    logic              commit;
    logic              enable_req;
    logic [c_wd_w-1:0] wd_timeout;
    logic [c_pw-1:0]   pos_in;
    logic [c_vw-1:0]   vel_out;
    logic              sg_enable;
    logic [c_pw-1:0]   snap_pos;
    logic              snap_valid;
    logic              wd_tripped;
    logic [1:0]        state_o;

    int n_checks = 0;
    int n_errors = 0;

    stepgen_sched #(
        .N         (c_n),
        .W         (c_w),
        .F         (c_f),
        .WD_W      (c_wd_w),
        .DRAIN_CYC (66)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .wr_data    (wr_data),
        .commit     (commit),
        .enable_req (enable_req),
        .wd_timeout (wd_timeout),
        .pos_in     (pos_in),
        .vel_out    (vel_out),
        .sg_enable  (sg_enable),
        .snap_pos   (snap_pos),
        .snap_valid (snap_valid),
        .wd_tripped (wd_tripped),
        .state_o    (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         wr_en;
        logic [1:0]   wr_sel;
        logic [10:0]  wr_data;
        logic         commit;
        logic         en;
        logic [1:0]   st;
        logic [32:0]  vel;
        logic         sg;
        logic         sv;
    } vec_t;

    vec_t vecs [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Counts consecutive DRAIN samples starting from the current one
    task automatic measure_drain(input int start, output int cnt, output bit sg_ok);
        cnt   = start;
        sg_ok = 1'b1;
        while (state_o == c_drain && cnt < 200) begin
            if (!sg_enable) sg_ok = 1'b0;
            tick();
            if (state_o == c_drain) cnt++;
        end
    endtask

    int cycles;
    int dcnt;
    bit sg_ok;
    int pulses;
    int bad;

    initial begin
        vecs[0] = '{1'b1, 2'd0, 11'h005, 1'b0, 1'b0, c_idle,  33'h0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 2'd1, 11'h7FB, 1'b0, 1'b1, c_idle,  33'h0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 2'd0, 11'h000, 1'b1, 1'b1, c_run,   {11'h000, 11'h7FB, 11'h005}, 1'b1, 1'b1};
        vecs[3] = '{1'b0, 2'd0, 11'h000, 1'b0, 1'b1, c_run,   {11'h000, 11'h7FB, 11'h005}, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 2'd2, 11'h123, 1'b1, 1'b1, c_run,   {11'h123, 11'h7FB, 11'h005}, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 2'd3, 11'h3FF, 1'b0, 1'b1, c_run,   {11'h123, 11'h7FB, 11'h005}, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 2'd0, 11'h000, 1'b1, 1'b1, c_run,   {11'h123, 11'h7FB, 11'h005}, 1'b1, 1'b1};
        vecs[7] = '{1'b1, 2'd0, 11'h400, 1'b0, 1'b1, c_run,   {11'h123, 11'h7FB, 11'h005}, 1'b1, 1'b0};
        vecs[8] = '{1'b0, 2'd0, 11'h000, 1'b1, 1'b0, c_drain, 33'h0, 1'b1, 1'b0};
        vecs[9] = '{1'b0, 2'd0, 11'h000, 1'b1, 1'b1, c_drain, 33'h0, 1'b1, 1'b0};

        reset      = 1'b1;
        wr_en      = 1'b0;
        wr_sel     = 2'd0;
        wr_data    = '0;
        commit     = 1'b0;
        enable_req = 1'b0;
        wd_timeout = '0;
        pos_in     = {22'h2AAAAA, 22'h000123, 22'h3FFFFF};
        tick();
        tick();
        reset = 1'b0;
        check("reset state", state_o, c_idle);
        check("reset vel", vel_out, 0);
        check("reset sg_enable", sg_enable, 0);
        check("reset snap_pos", snap_pos, 0);
        check("reset snap_valid", snap_valid, 0);
        check("reset wd_tripped", wd_tripped, 0);

        for (int i = 0; i < 10; i++) begin
            wr_en      = vecs[i].wr_en;
            wr_sel     = vecs[i].wr_sel;
            wr_data    = vecs[i].wr_data;
            commit     = vecs[i].commit;
            enable_req = vecs[i].en;
            tick();
            check($sformatf("vec%0d state", i), state_o, vecs[i].st);
            check($sformatf("vec%0d vel", i), vel_out, vecs[i].vel);
            check($sformatf("vec%0d sg_enable", i), sg_enable, vecs[i].sg);
            check($sformatf("vec%0d snap_valid", i), snap_valid, vecs[i].sv);
        end
        wr_en  = 1'b0;
        commit = 1'b0;
        check("table snap_pos", snap_pos, {22'h2AAAAA, 22'h000123, 22'h3FFFFF});

        // Host-initiated drain: rows 8 and 9 already observed two DRAIN cycles
        measure_drain(2, dcnt, sg_ok);
        check("host drain length", dcnt, 66);
        check("host drain sg held", sg_ok, 1);
        check("host drain end state", state_o, c_idle);
        check("host drain wd_tripped", wd_tripped, 0);
        check("host drain sg off", sg_enable, 0);

        // Watchdog expiry after a single commit
        wd_timeout = 8'd10;
        enable_req = 1'b1;
        commit     = 1'b1;
        tick();
        commit = 1'b0;
        check("wd commit state", state_o, c_run);
        check("wd commit vel", vel_out, {11'h123, 11'h7FB, 11'h400});
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (state_o == c_run && cycles < 50);
        check("wd expiry cycles", cycles, 10);
        check("wd expiry state", state_o, c_drain);
        check("wd expiry vel", vel_out, 0);
        measure_drain(1, dcnt, sg_ok);
        check("wd drain length", dcnt, 66);
        check("wd drain sg held", sg_ok, 1);
        check("wd fault state", state_o, c_fault);
        check("wd fault tripped", wd_tripped, 1);
        check("wd fault sg off", sg_enable, 0);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        check("fault commit state", state_o, c_fault);
        check("fault commit snap_valid", snap_valid, 0);
        check("fault commit vel", vel_out, 0);
        enable_req = 1'b0;
        tick();
        check("fault clear state", state_o, c_idle);
        check("fault clear tripped", wd_tripped, 0);

        // Commits every 8 cycles keep the watchdog fed
        enable_req = 1'b1;
        pulses = 0;
        bad    = 0;
        for (int k = 0; k < 12; k++) begin
            pos_in = {22'(k * 3 + 1), 22'(k * 5 + 2), 22'(k * 7 + 3)};
            commit = 1'b1;
            tick();
            commit = 1'b0;
            if (snap_valid) pulses++;
            if (state_o != c_run) bad++;
            for (int j = 0; j < 7; j++) begin
                tick();
                if (snap_valid) pulses++;
                if (state_o != c_run) bad++;
            end
        end
        pos_in = '0;
        tick();
        check("fed run stayed RUN", bad, 0);
        check("fed run snap pulses", pulses, 12);
        check("fed run snap_pos held", snap_pos, {22'd34, 22'd57, 22'd80});

        // Reset in the middle of a drain
        enable_req = 1'b0;
        tick();
        check("pre-reset state", state_o, c_drain);
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid-drain reset state", state_o, c_idle);
        check("mid-drain reset vel", vel_out, 0);
        check("mid-drain reset sg", sg_enable, 0);
        check("mid-drain reset snap_pos", snap_pos, 0);
        check("mid-drain reset tripped", wd_tripped, 0);

        // Watchdog disabled: well past a full 8-bit wrap without tripping
        wd_timeout = '0;
        enable_req = 1'b1;
        wr_en      = 1'b1;
        wr_sel     = 2'd1;
        wr_data    = 11'h0AB;
        commit     = 1'b1;
        tick();
        wr_en  = 1'b0;
        commit = 1'b0;
        check("nowd commit vel", vel_out, {11'h000, 11'h0AB, 11'h000});
        bad = 0;
        for (int c = 0; c < 300; c++) begin
            tick();
            if (state_o != c_run) bad++;
        end
        check("nowd stayed RUN", bad, 0);
        check("nowd tripped", wd_tripped, 0);
        check("nowd vel held", vel_out, {11'h000, 11'h0AB, 11'h000});

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stepgen_sched.md
Name: stepgen_sched

Overview:
- Multi-axis sequencer in front of N stepgen instances.
- Host writes per-axis velocity words into shadow registers. A single commit strobe applies all of them to the stepgens in the same cycle and snapshots every axis position for readback.
- A watchdog ramps the axes to a safe stop when commits stop arriving.
- Owns the shared stepgen `enable` and the enable/disable sequencing.

Parameters:
- N, 4, number of stepgen axes.
- W, 12, integer position bits (matches stepgen W).
- F, 10, fractional bits; velocity word is F+1 bits, position word is W+F bits.
- WD_W, 24, watchdog counter width in clk cycles.
- DRAIN_CYC, 66, cycles `sg_enable` stays high with zero velocity before disabling. Covers one steptime plus one dirtime at T=5: 2*2^5+2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  shadow register write strobe
- wr_sel  in  $clog2(N)  axis index for write
- wr_data  in  F+1  signed velocity word (bit F = direction)
- commit  in  1  single-cycle strobe: shadow to active, plus position snapshot
- enable_req  in  1  host run request (level)
- wd_timeout  in  WD_W  watchdog reload value; 0 disables the watchdog
- pos_in  in  N*(W+F)  out_position buses from the stepgens, axis 0 in the LSBs
- vel_out  out  N*(F+1)  velocity buses to the stepgens, axis 0 in the LSBs
- sg_enable  out  1  common enable to all stepgens
- snap_pos  out  N*(W+F)  positions captured at the last accepted commit
- snap_valid  out  1  one-cycle pulse, snapshot updated
- wd_tripped  out  1  sticky fault flag
- state_o  out  2  current state, for debug

Behaviour:
- Reset values:
  - State is IDLE.
  - Shadow regs, vel_out and snap_pos are 0.
  - sg_enable, snap_valid and wd_tripped are 0.
  - Watchdog counter is 0.
- Shadow write:
  - On `wr_en`, shadow[wr_sel] <= wr_data in any state.
  - wr_sel >= N is ignored.
- Effective shadow: if wr_en and commit occur in the same cycle, the commit uses the new wr_data for that axis (write-through).
- States are IDLE=0, RUN=1, DRAIN=2, FAULT=3.
- IDLE:
  - vel_out = 0, sg_enable = 0.
  - commit && enable_req → RUN. That same edge performs the commit action and sets sg_enable = 1.
  - commit with enable_req = 0 is ignored (no snapshot).
- Commit action (when accepted):
  - vel_out <= effective shadow.
  - snap_pos <= pos_in.
  - watchdog counter <= wd_timeout.
  - snap_valid = 1 in the cycle after the commit edge only.
- RUN:
  - Watchdog decrements each cycle while nonzero and wd_timeout != 0.
  - The transition out of RUN happens on the edge where the counter goes 1→0 with no commit in that cycle. Commit in that cycle wins.
  - Watchdog expiry → DRAIN with fault pending.
  - enable_req = 0 → DRAIN with no fault; this takes priority over a commit in the same cycle.
- DRAIN:
  - On entry, vel_out <= 0 and sg_enable stays 1.
  - Drain counter loads DRAIN_CYC-1 and counts down.
  - At 0: fault pending → FAULT; otherwise → IDLE. sg_enable <= 0 on that edge.
  - Commit is ignored; enable_req is ignored.
- FAULT:
  - vel_out = 0, sg_enable = 0, wd_tripped = 1.
  - enable_req sampled 0 → IDLE and wd_tripped clears on the same edge.
  - commit is ignored.
- Reset mid-operation returns every register to its reset value on the next edge, with no drain.
- No arithmetic on velocity: a pure register path. Width-exact concatenation, no sign extension.

Decomposition:
- Package stepgen_pkg holds:
  - state encodings ST_IDLE, ST_RUN, ST_DRAIN, ST_FAULT;
  - a function for the axis slice offset (idx*(F+1), idx*(W+F));
  - the default DRAIN_CYC constant.
- One sub-module, stepgen_wdog: loadable down-counter with a zero-disable input and an `expire` pulse. It is reused for both the watchdog and the drain counter via separate instances.

Test Plan:
- Write axis0 = 0x005, axis1 = 0x7FB, then commit with enable_req = 1 → next cycle vel_out slices are 0x005 and 0x7FB, sg_enable = 1, state RUN, snap_valid pulses once and snap_pos equals pos_in.
- wd_timeout = 10, single commit, no further commits → after 10 cycles state DRAIN and vel_out = 0. sg_enable stays high for 66 cycles, then state FAULT, wd_tripped = 1. Drop enable_req → IDLE, wd_tripped = 0.
- wd_timeout = 10 with a commit every 8 cycles for 100 cycles → never leaves RUN, and snap_valid pulses 12 times.
- In RUN, deassert enable_req → DRAIN for 66 cycles, then IDLE with wd_tripped = 0. A commit during DRAIN leaves vel_out = 0 and produces no snap_valid.
- wr_en with wr_sel = 2, wr_data = 0x123 and commit in the same cycle → vel_out axis2 = 0x123. wr_sel = N is ignored: the other shadows are unchanged.
- Assert reset mid-DRAIN → next cycle IDLE with all outputs 0. wd_timeout = 0 in RUN → no trip after 2^WD_W cycles (spot-checked with WD_W = 8).
